// File: rtl/ahb_sub_mem.sv
`default_nettype none
// ============================================================================
// Module   : ahb_sub_mem
// Purpose  : AHB-Lite subordinate backed by a word-organised memory array.
//            Each beat is handled alone, with optional fixed wait states
//            and a two-cycle ERROR response for illegal transfers.
// Revision : 1.0 - initial release
// ============================================================================
module ahb_sub_mem #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int MEM_DEPTH   = 256,
    parameter int WAIT_STATES = 0
) (
    input  logic                  HCLK,
    input  logic                  HRESETn,
    input  logic                  HSEL,
    input  logic [ADDR_WIDTH-1:0] HADDR,
    input  logic                  HWRITE,
    input  logic [2:0]            HSIZE,
    input  logic [2:0]            HBURST,
    input  logic [3:0]            HPROT,
    input  logic [1:0]            HTRANS,
    input  logic [DATA_WIDTH-1:0] HWDATA,
    input  logic                  HREADY,
    output logic                  HREADYOUT,
    output logic [1:0]            HRESP,
    output logic [DATA_WIDTH-1:0] HRDATA
);

    localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ERR1 = 2'd2,
        ST_ERR2 = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [3:0]         cnt_q, cnt_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [1:0]         lo_q, lo_d;
    logic [2:0]         size_q, size_d;
    logic               write_q, write_d;
    logic               active_q, active_d;   // an OKAY data phase is in flight
    logic               ready_q, ready_d;
    logic [1:0]         resp_q, resp_d;

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    logic [ADDR_WIDTH-1:0] w_word_idx;
    logic                  w_err;
    logic                  w_accept;
    logic                  w_final_ok;
    logic [3:0]            w_be;
    logic                  w_unused;

    // Burst type and protection carry no meaning for a single-beat memory.
    assign w_unused   = ^{HBURST, HPROT};

    assign w_word_idx = {2'b00, HADDR[ADDR_WIDTH-1:2]};
    assign w_err      = (w_word_idx >= ADDR_WIDTH'(MEM_DEPTH))
                      || (HSIZE > 3'b010)
                      || ((HSIZE == 3'b001) && HADDR[0])
                      || ((HSIZE == 3'b010) && (HADDR[1:0] != 2'b00));

    // New beats are only taken in a cycle where this subordinate is ready,
    // which is exactly the last cycle of any data phase (or plain idle).
    assign w_accept   = HSEL && HREADY && HTRANS[1] && ready_q;
    assign w_final_ok = active_q && ready_q;

    assign HREADYOUT  = ready_q;
    assign HRESP      = resp_q;
    assign HRDATA     = (w_final_ok && !write_q) ? mem[idx_q] : '0;

    // Next-state and registered-output computation for the transfer FSM.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        lo_d     = lo_q;
        size_d   = size_q;
        write_d  = write_q;
        active_d = active_q;
        ready_d  = ready_q;
        resp_d   = resp_q;
        if (ready_q) begin
            if (w_accept) begin
                idx_d   = HADDR[IDX_W+1:2];
                lo_d    = HADDR[1:0];
                size_d  = HSIZE;
                write_d = HWRITE;
                if (w_err) begin
                    state_d  = ST_ERR1;
                    active_d = 1'b0;
                    ready_d  = 1'b0;
                    resp_d   = 2'b01;
                end else if (WAIT_STATES > 0) begin
                    state_d  = ST_WAIT;
                    cnt_d    = 4'(WAIT_STATES);
                    active_d = 1'b1;
                    ready_d  = 1'b0;
                    resp_d   = 2'b00;
                end else begin
                    state_d  = ST_IDLE;
                    active_d = 1'b1;
                    ready_d  = 1'b1;
                    resp_d   = 2'b00;
                end
            end else begin
                state_d  = ST_IDLE;
                active_d = 1'b0;
                ready_d  = 1'b1;
                resp_d   = 2'b00;
            end
        end else begin
            case (state_q)
                ST_ERR1: begin
                    state_d = ST_ERR2;
                    ready_d = 1'b1;
                    resp_d  = 2'b01;
                end
                ST_WAIT: begin
                    cnt_d   = cnt_q - 4'd1;
                    ready_d = (cnt_q == 4'd1);
                end
                default: begin
                    state_d  = ST_IDLE;
                    active_d = 1'b0;
                    ready_d  = 1'b1;
                    resp_d   = 2'b00;
                end
            endcase
        end
    end

    // State registers; reset abandons any transfer in flight.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q  <= ST_IDLE;
            cnt_q    <= 4'd0;
            idx_q    <= '0;
            lo_q     <= 2'b00;
            size_q   <= 3'b000;
            write_q  <= 1'b0;
            active_q <= 1'b0;
            ready_q  <= 1'b1;
            resp_q   <= 2'b00;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            lo_q     <= lo_d;
            size_q   <= size_d;
            write_q  <= write_d;
            active_q <= active_d;
            ready_q  <= ready_d;
            resp_q   <= resp_d;
        end
    end

    // Byte lanes touched by the captured beat, little-endian.
    always_comb begin
        w_be = 4'b1111;
        case (size_q)
            3'b000:  w_be = 4'b0001 << lo_q;
            3'b001:  w_be = lo_q[1] ? 4'b1100 : 4'b0011;
            default: w_be = 4'b1111;
        endcase
    end

    // Write commit at the edge closing an OKAY write data phase; no reset.
    always_ff @(posedge HCLK) begin
        if (w_final_ok && write_q) begin
            for (int b = 0; b < 4; b++) begin
                if (w_be[b]) begin
                    mem[idx_q][8*b +: 8] <= HWDATA[8*b +: 8];
                end
            end
        end
    end

endmodule
`default_nettype wire
